// File: rtl/zxuno_regbus_master_pkg.sv
// zxuno_regbus_master_pkg: shared I/O port addresses, settle default and FSM state type
package zxuno_regbus_master_pkg;
   localparam logic [15:0] IOADDR_DEF = 16'hFC3B;
   localparam logic [15:0] IODATA_DEF = 16'hFD3B;
   localparam int WR_SETTLE_DEF = 2;
   typedef enum logic [1:0] {IDLE, WR_SETTLE_CNT, RD_ACTIVE, WAIT_END} state_t;
endpackage

// File: rtl/zxuno_regbus_master_if.sv
// zxuno_regbus_master_if: Z80 I/O bus and register-slave bus bundle
//  master: the bus master block (CPU bus in, slave strobes/data out)
//  slave : the surrounding CPU glue and register slaves
interface zxuno_regbus_master_if;
   logic [15:0] a;
   logic iorq_n, rd_n, wr_n, m1_n;
   logic [7:0] cpudout, cpudin;
   logic oe_n;
   logic [7:0] zxuno_addr;
   logic zxuno_regwr, zxuno_regrd;
   logic [7:0] din, periph_dout;
   logic periph_oe_n;
   modport master (
      input a, iorq_n, rd_n, wr_n, m1_n, cpudout, periph_dout, periph_oe_n,
      output cpudin, oe_n, zxuno_addr, zxuno_regwr, zxuno_regrd, din
   );
   modport slave (
      output a, iorq_n, rd_n, wr_n, m1_n, cpudout, periph_dout, periph_oe_n,
      input cpudin, oe_n, zxuno_addr, zxuno_regwr, zxuno_regrd, din
   );
endinterface

// File: rtl/zxuno_regbus_master_iocycle_detect.sv
// zxuno_iocycle_detect: decodes Z80 I/O cycles to the register ports and runs the cycle FSM
//  in : clk, rst, a, iorq_n, rd_n, wr_n, m1_n
//  out: commit (write settled this clk), rd_state (in read cycle), rd_hold (read still asserted),
//       port_data (current cycle targets the data port)
module zxuno_iocycle_detect
   import zxuno_regbus_master_pkg::*;
#(
   parameter logic [15:0] IOADDR = IOADDR_DEF,
   parameter logic [15:0] IODATA = IODATA_DEF,
   parameter int WR_SETTLE = WR_SETTLE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic [15:0] a,
   input  logic iorq_n,
   input  logic rd_n,
   input  logic wr_n,
   input  logic m1_n,
   output logic commit,
   output logic rd_state,
   output logic rd_hold,
   output logic port_data
);
   state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic pd_nxt, iowr, iord, hit;
   // M1 low with IORQ low is an interrupt acknowledge and must never decode
   assign iowr = ~iorq_n & ~wr_n & m1_n;
   assign iord = ~iorq_n & ~rd_n & m1_n;
   assign hit = a == IOADDR || a == IODATA;
   assign rd_state = state == RD_ACTIVE;
   assign rd_hold = rd_state & iord;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_END;
         cnt <= '0;
         port_data <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         port_data <= pd_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      pd_nxt = port_data;
      commit = 1'b0;
      case (state)
         IDLE: if (hit && (iowr || iord)) begin
            state_nxt = iowr ? WR_SETTLE_CNT : RD_ACTIVE;
            cnt_nxt = '0;
            pd_nxt = a == IODATA;
         end
         WR_SETTLE_CNT: if (!iowr) state_nxt = IDLE;
            else if (cnt == 3'(WR_SETTLE - 1)) begin
               commit = 1'b1;
               state_nxt = WAIT_END;
            end else cnt_nxt = cnt + 3'd1;
         RD_ACTIVE: if (!iord) state_nxt = IDLE;
         default: if (iorq_n) state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/zxuno_regbus_master.sv
// zxuno_regbus_master: ZXUNO register bus initiator (register select, write strobe, read return)
//  in : clk, rst (sync, active high)
//  bus: zxuno_regbus_master_if.master -- Z80 I/O signals, slave read data, slave strobes and cpudin/oe_n
module zxuno_regbus_master
   import zxuno_regbus_master_pkg::*;
#(
   parameter logic [15:0] IOADDR = IOADDR_DEF,
   parameter logic [15:0] IODATA = IODATA_DEF,
   parameter int WR_SETTLE = WR_SETTLE_DEF
) (
   input logic clk,
   input logic rst,
   zxuno_regbus_master_if.master bus
);
   logic commit, rd_state, rd_hold, port_data;
   zxuno_iocycle_detect #(.IOADDR(IOADDR), .IODATA(IODATA), .WR_SETTLE(WR_SETTLE)) u_det (
      .clk(clk), .rst(rst), .a(bus.a), .iorq_n(bus.iorq_n), .rd_n(bus.rd_n),
      .wr_n(bus.wr_n), .m1_n(bus.m1_n), .commit(commit), .rd_state(rd_state),
      .rd_hold(rd_hold), .port_data(port_data)
   );
   // regrd is a level tied to the read state so it drops on the same edge the cycle ends
   assign bus.zxuno_regrd = rd_state & port_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.zxuno_addr <= 8'h00;
         bus.zxuno_regwr <= 1'b0;
         bus.din <= 8'h00;
         bus.cpudin <= 8'h00;
         bus.oe_n <= 1'b1;
      end else begin
         bus.zxuno_regwr <= commit & port_data;
         if (commit & ~port_data) bus.zxuno_addr <= bus.cpudout;
         if (commit & port_data) bus.din <= bus.cpudout;
         if (rd_hold & ~port_data) begin
            bus.cpudin <= bus.zxuno_addr;
            bus.oe_n <= 1'b0;
         end else if (rd_hold & ~bus.periph_oe_n) begin
            bus.cpudin <= bus.periph_dout;
            bus.oe_n <= 1'b0;
         end else bus.oe_n <= 1'b1;
      end
   end
endmodule
